// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  // Register $zero is never a real producer, so it can never create a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dest);
    return (dest != ZERO_REG) && (src == dest);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational detection of RAW hazards that forwarding cannot resolve.
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic [REG_W-1:0] src3,
  input  logic             two_src,
  input  logic             if_store_bne,
  input  logic [REG_W-1:0] EXE_Dest,
  input  logic             EXE_WB_EN,
  input  logic             EXE_MEM_R_EN,
  input  logic [REG_W-1:0] MEM_Dest,
  input  logic             MEM_WB_EN,
  input  logic             forwarding_enable,
  output logic             hazard
);

  logic reads_src2;
  logic reads_src3;
  logic exe_hit;
  logic mem_hit;

  // STORE/BNE read src3 in place of src2.
  assign reads_src2 = two_src & ~if_store_bne;
  assign reads_src3 = if_store_bne;

  assign exe_hit = reg_match(src1, EXE_Dest)
                 | (reads_src2 & reg_match(src2, EXE_Dest))
                 | (reads_src3 & reg_match(src3, EXE_Dest));

  assign mem_hit = reg_match(src1, MEM_Dest)
                 | (reads_src2 & reg_match(src2, MEM_Dest))
                 | (reads_src3 & reg_match(src3, MEM_Dest));

  // With forwarding only a load in EXE is too late; without it any pending write stalls.
  always_comb begin
    if (forwarding_enable)
      hazard = EXE_MEM_R_EN & EXE_WB_EN & exe_hit;
    else
      hazard = (EXE_WB_EN & exe_hit) | (MEM_WB_EN & mem_hit);
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: hazard stalls, branch flush and SRAM freeze with timeout.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 63,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic [REG_W-1:0] src3,
  input  logic             two_src,
  input  logic             if_store_bne,
  input  logic [REG_W-1:0] EXE_Dest,
  input  logic             EXE_WB_EN,
  input  logic             EXE_MEM_R_EN,
  input  logic [REG_W-1:0] MEM_Dest,
  input  logic             MEM_WB_EN,
  input  logic             forwarding_enable,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             sram_start,
  output logic             freeze_all,
  output logic             freeze_front,
  output logic             bubble_ID_EX,
  output logic             flush_IF_ID,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  mem_state_t     state, state_next;
  logic [WCW-1:0] wait_cnt, wait_cnt_next;
  logic           start_raw;
  logic           freeze_raw;
  logic           timeout_hit;
  logic           hazard;
  logic           front_raw;
  logic           bubble_raw;
  logic           flush_raw;

  hazard_detect u_detect (
    .src1              (src1),
    .src2              (src2),
    .src3              (src3),
    .two_src           (two_src),
    .if_store_bne      (if_store_bne),
    .EXE_Dest          (EXE_Dest),
    .EXE_WB_EN         (EXE_WB_EN),
    .EXE_MEM_R_EN      (EXE_MEM_R_EN),
    .MEM_Dest          (MEM_Dest),
    .MEM_WB_EN         (MEM_WB_EN),
    .forwarding_enable (forwarding_enable),
    .hazard            (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // The final wait cycle still freezes; release happens the cycle after timeout.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    start_raw     = 1'b0;
    freeze_raw    = 1'b0;
    timeout_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          start_raw     = 1'b1;
          freeze_raw    = 1'b1;
          state_next    = WAIT;
          wait_cnt_next = '0;
        end
      end
      WAIT: begin
        if (sram_ready) begin
          state_next = IDLE;
        end else begin
          freeze_raw = 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            timeout_hit   = 1'b1;
            state_next    = IDLE;
            wait_cnt_next = '0;
          end else begin
            wait_cnt_next = wait_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A taken branch outranks a hazard: the stalled instruction is wrong-path anyway.
  assign front_raw  = ~freeze_raw & ~branch_taken & hazard;
  assign bubble_raw = ~freeze_raw & (branch_taken | hazard);
  assign flush_raw  = ~freeze_raw & branch_taken;

  assign sram_start   = start_raw  & ~rst;
  assign freeze_all   = freeze_raw & ~rst;
  assign freeze_front = front_raw  & ~rst;
  assign bubble_ID_EX = bubble_raw & ~rst;
  assign flush_IF_ID  = flush_raw  & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_count <= '0;
    else if (front_raw && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mem_timeout_err <= 1'b0;
    else if (timeout_hit)
      mem_timeout_err <= 1'b1;
  end

endmodule
